// File: rtl/risk_mem_ctrl.sv
`timescale 1ns/1ps
// Round-robin sequencer for risk_mem: streams one tile access per cycle per command,
// aligns write data/enable to the memory pipeline and tags read returns with owner/last.
module risk_mem_ctrl #(
  parameter int SZ     = 4,
  parameter int LOGCNT = 5,
  parameter int BITS   = 18,
  parameter int CNTW   = 8,
  parameter int RD_LAT = 4,
  localparam int AW    = 10 + LOGCNT,
  localparam int DW    = BITS * SZ * SZ
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            cmd_valid,
  output logic [1:0]            cmd_ready,
  input  logic [1:0]            cmd_we,
  input  logic [2*AW-1:0]       cmd_addr,
  input  logic [2*(AW-1)-1:0]   cmd_stride_x,
  input  logic [2*(AW-1)-1:0]   cmd_stride_y,
  input  logic [2*AW-1:0]       cmd_step,
  input  logic [2*CNTW-1:0]     cmd_count,
  input  logic [2*DW-1:0]       wr_data,
  input  logic [1:0]            wr_valid,
  output logic [1:0]            wr_ready,
  output logic [DW-1:0]         rd_data,
  output logic                  rd_valid,
  output logic                  rd_id,
  output logic                  rd_last,
  output logic [1:0]            done,
  output logic [AW-1:0]         mem_addr,
  output logic [AW-2:0]         mem_stride_x,
  output logic [AW-2:0]         mem_stride_y,
  output logic [DW-1:0]         mem_dat_w,
  output logic                  mem_we,
  input  logic [DW-1:0]         mem_dat_r
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW-1:0]     step_q, step_d;
  logic [AW-2:0]     sx_q, sx_d;
  logic [AW-2:0]     sy_q, sy_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [RD_LAT-1:0] rdv_q;
  logic              we1_q, we2_q;
  logic [DW-1:0]     dat_w_q;

  logic              any_vld, gsel, accept, issue, last_issue, drain_done;
  logic              sel_we;
  logic [AW-1:0]     sel_addr, sel_step;
  logic [AW-2:0]     sel_sx, sel_sy;
  logic [CNTW-1:0]   sel_cnt;
  logic [DW-1:0]     own_wr_data;

  // Favour the pointed-to requester, fall back to the other one.
  assign any_vld  = |cmd_valid;
  assign gsel     = cmd_valid[ptr_q] ? ptr_q : ~ptr_q;
  assign accept   = (state_q == ST_IDLE) && any_vld;

  assign sel_we   = gsel ? cmd_we[1] : cmd_we[0];
  assign sel_addr = gsel ? cmd_addr[2*AW-1:AW] : cmd_addr[AW-1:0];
  assign sel_step = gsel ? cmd_step[2*AW-1:AW] : cmd_step[AW-1:0];
  assign sel_sx   = gsel ? cmd_stride_x[2*(AW-1)-1:AW-1] : cmd_stride_x[AW-2:0];
  assign sel_sy   = gsel ? cmd_stride_y[2*(AW-1)-1:AW-1] : cmd_stride_y[AW-2:0];
  assign sel_cnt  = gsel ? cmd_count[2*CNTW-1:CNTW] : cmd_count[CNTW-1:0];

  assign own_wr_data = gnt_q ? wr_data[2*DW-1:DW] : wr_data[DW-1:0];

  // RUN always has at least one tile outstanding, so no count test is needed here.
  assign issue      = (state_q == ST_RUN) && (!we_q || wr_valid[gnt_q]);
  assign last_issue = issue && (cnt_q == CNTW'(1));

  // Drain ends when only the output stage of the read pipe is occupied, or the write pipe is empty.
  assign drain_done = (state_q == ST_DRAIN) &&
                      (we_q ? !(we1_q || we2_q) : (rdv_q[RD_LAT-2:0] == '0));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (any_vld) state_d = (sel_cnt == '0) ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d  = ptr_q;
    gnt_d  = gnt_q;
    we_d   = we_q;
    addr_d = addr_q;
    step_d = step_q;
    sx_d   = sx_q;
    sy_d   = sy_q;
    cnt_d  = cnt_q;
    if (accept) begin
      ptr_d  = ~gsel;
      gnt_d  = gsel;
      we_d   = sel_we;
      step_d = sel_step;
      cnt_d  = sel_cnt;
      // A zero-count command touches nothing, so the memory-facing address keeps its value.
      if (sel_cnt != '0) begin
        addr_d = sel_addr;
        sx_d   = sel_sx;
        sy_d   = sel_sy;
      end
    end else if (issue) begin
      cnt_d = cnt_q - CNTW'(1);
      if (!last_issue) addr_d = addr_q + step_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      step_q  <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      cnt_q   <= '0;
      rdv_q   <= '0;
      we1_q   <= 1'b0;
      we2_q   <= 1'b0;
      dat_w_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      step_q  <= step_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      cnt_q   <= cnt_d;
      rdv_q   <= {rdv_q[RD_LAT-2:0], issue && !we_q};
      we1_q   <= issue && we_q;
      we2_q   <= we1_q;
      if (issue && we_q) dat_w_q <= own_wr_data;
    end
  end

  always_comb begin
    cmd_ready = '0;
    wr_ready  = '0;
    done      = '0;
    // Gated by reset so a requester holding valid through reset sees no grant.
    if (accept && resetn)                  cmd_ready[gsel]  = 1'b1;
    if ((state_q == ST_RUN) && we_q)       wr_ready[gnt_q]  = 1'b1;
    if (drain_done)                        done[gnt_q]      = 1'b1;
    rd_valid     = rdv_q[RD_LAT-1];
    rd_id        = rd_valid && gnt_q;
    rd_last      = rd_valid && drain_done;
    rd_data      = rd_valid ? mem_dat_r : '0;
    mem_addr     = addr_q;
    mem_stride_x = sx_q;
    mem_stride_y = sy_q;
    mem_dat_w    = dat_w_q;
    mem_we       = we2_q;
  end

endmodule

// File: tb/tb_risk_mem_ctrl.sv
`timescale 1ns/1ps
// Randomized self-checking bench for risk_mem_ctrl against an event-schedule reference model.
module tb_risk_mem_ctrl;
  localparam int AW = 15;
  localparam int DW = 288;
  localparam int CNTW = 8;
  localparam int RDL = 4;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [1:0]           cmd_valid, cmd_ready, cmd_we, wr_valid, wr_ready, done;
  logic [2*AW-1:0]      cmd_addr, cmd_step;
  logic [2*(AW-1)-1:0]  cmd_stride_x, cmd_stride_y;
  logic [2*CNTW-1:0]    cmd_count;
  logic [2*DW-1:0]      wr_data;
  logic [DW-1:0]        rd_data, mem_dat_w, mem_dat_r;
  logic                 rd_valid, rd_id, rd_last, mem_we;
  logic [AW-1:0]        mem_addr;
  logic [AW-2:0]        mem_stride_x, mem_stride_y;

  int   checks = 0;
  int   failures = 0;
  logic ptr_m;

  always #5 clk = ~clk;

  risk_mem_ctrl dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_stride_x(cmd_stride_x), .cmd_stride_y(cmd_stride_y),
    .cmd_step(cmd_step), .cmd_count(cmd_count),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_id(rd_id), .rd_last(rd_last),
    .done(done),
    .mem_addr(mem_addr), .mem_stride_x(mem_stride_x), .mem_stride_y(mem_stride_y),
    .mem_dat_w(mem_dat_w), .mem_we(mem_we), .mem_dat_r(mem_dat_r)
  );

  function automatic logic [DW-1:0] rand_dw();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DW/32; i++) v = {v[DW-33:0], $urandom};
    return v;
  endfunction

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and checks every cycle until one cycle past done.
  task automatic run_cmd(input logic r, input logic we, input logic [AW-1:0] base,
                         input logic [AW-1:0] stp, input logic [AW-2:0] sx,
                         input logic [AW-2:0] sy, input int n, input logic use_pat,
                         input logic [63:0] pat, input logic both);
    logic          g;
    logic [1:0]    oh;
    logic [63:0]   wv, e_we, e_rdv, e_last, e_done, e_wrr, e_dw, e_av;
    logic [AW-1:0] e_addr [64];
    int            e_tile [64];
    logic [DW-1:0] tiles [$];
    int            k, last, done_d, span, k_drv;
    logic          acc;

    g = both ? ptr_m : r;
    oh = 2'b00;
    oh[g] = 1'b1;
    e_we = '0; e_rdv = '0; e_last = '0; e_done = '0; e_wrr = '0; e_dw = '0; e_av = '0;
    for (int d = 0; d < 64; d++) begin
      e_addr[d] = '0;
      e_tile[d] = 0;
      wv[d] = use_pat ? pat[d] : ($urandom_range(0, 2) != 0);
      if (d > 40) wv[d] = 1'b1;
    end
    for (int i = 0; i < n; i++) tiles.push_back(rand_dw());

    k = 0; last = 0;
    if (n == 0) begin
      done_d = 1;
    end else if (!we) begin
      for (int d = 1; d <= n; d++) begin
        e_av[d] = 1'b1;
        e_addr[d] = base + stp * AW'(d - 1);
      end
      for (int d = 1 + RDL; d <= n + RDL; d++) e_rdv[d] = 1'b1;
      e_last[n + RDL] = 1'b1;
      done_d = n + RDL;
    end else begin
      for (int d = 1; k < n; d++) begin
        e_av[d] = 1'b1;
        e_addr[d] = base + stp * AW'(k);
        e_wrr[d] = 1'b1;
        if (wv[d]) begin
          e_dw[d + 1] = 1'b1;
          e_tile[d + 1] = k;
          e_we[d + 2] = 1'b1;
          k++;
          last = d;
        end
      end
      done_d = last + 3;
    end
    e_done[done_d] = 1'b1;
    span = done_d + 1;

    cmd_we = {we, we};
    cmd_addr = {base, base};
    cmd_step = {stp, stp};
    cmd_stride_x = {sx, sx};
    cmd_stride_y = {sy, sy};
    cmd_count = {CNTW'(n), CNTW'(n)};
    cmd_valid = both ? 2'b11 : oh;

    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready != 2'b00) acc = 1'b1;
      else step_cycle();
    end
    checks++;
    if (!acc || cmd_ready !== oh) begin
      failures++;
      $display("FAIL accept got=%b exp=%b", cmd_ready, oh);
    end
    ptr_m = ~g;
    step_cycle();
    cmd_valid = 2'b00;
    if (!acc) return;

    k_drv = 0;
    for (int d = 1; d <= span; d++) begin
      wr_valid = 2'b00;
      wr_valid[g] = wv[d];
      wr_data = {rand_dw(), rand_dw()};
      if (k_drv < n) begin
        if (g) wr_data[2*DW-1:DW] = tiles[k_drv];
        else   wr_data[DW-1:0] = tiles[k_drv];
      end
      mem_dat_r = rand_dw();
      @(negedge clk);
      checks++;
      if (mem_we !== e_we[d]) begin
        failures++; $display("FAIL mem_we d=%0d got=%b exp=%b", d, mem_we, e_we[d]);
      end
      checks++;
      if (rd_valid !== e_rdv[d]) begin
        failures++; $display("FAIL rd_valid d=%0d got=%b exp=%b", d, rd_valid, e_rdv[d]);
      end
      checks++;
      if (rd_last !== e_last[d]) begin
        failures++; $display("FAIL rd_last d=%0d got=%b exp=%b", d, rd_last, e_last[d]);
      end
      checks++;
      if (done !== (e_done[d] ? oh : 2'b00)) begin
        failures++; $display("FAIL done d=%0d got=%b exp=%b", d, done, e_done[d] ? oh : 2'b00);
      end
      checks++;
      if (wr_ready !== (e_wrr[d] ? oh : 2'b00)) begin
        failures++; $display("FAIL wr_ready d=%0d got=%b exp=%b", d, wr_ready, e_wrr[d] ? oh : 2'b00);
      end
      checks++;
      if (cmd_ready !== 2'b00) begin
        failures++; $display("FAIL cmd_ready_busy d=%0d got=%b exp=00", d, cmd_ready);
      end
      if (e_rdv[d]) begin
        checks++;
        if (rd_data !== mem_dat_r || rd_id !== g) begin
          failures++; $display("FAIL rd_data d=%0d id=%b exp_id=%b data=%h exp=%h", d, rd_id, g, rd_data, mem_dat_r);
        end
      end
      if (e_av[d]) begin
        checks++;
        if (mem_addr !== e_addr[d] || mem_stride_x !== sx || mem_stride_y !== sy) begin
          failures++;
          $display("FAIL mem_addr d=%0d got=%h/%h/%h exp=%h/%h/%h", d, mem_addr, mem_stride_x, mem_stride_y, e_addr[d], sx, sy);
        end
      end
      if (e_dw[d]) begin
        checks++;
        if (mem_dat_w !== tiles[e_tile[d]]) begin
          failures++; $display("FAIL mem_dat_w d=%0d got=%h exp=%h", d, mem_dat_w, tiles[e_tile[d]]);
        end
      end
      if (we && e_wrr[d] && wv[d]) k_drv++;
      step_cycle();
    end
    wr_valid = 2'b00;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (cmd_ready !== 0 || wr_ready !== 0 || rd_valid !== 0 || rd_id !== 0 || rd_last !== 0 ||
        rd_data !== '0 || done !== 0 || mem_addr !== '0 || mem_stride_x !== '0 ||
        mem_stride_y !== '0 || mem_dat_w !== '0 || mem_we !== 0) begin
      failures++;
      $display("FAIL %s outputs not zero: rdy=%b wrr=%b rdv=%b done=%b addr=%h we=%b", name,
               cmd_ready, wr_ready, rd_valid, done, mem_addr, mem_we);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cmd_valid = 2'b11;
    wr_valid = 2'b11;
    mem_dat_r = rand_dw();
    repeat (3) step_cycle();
    check_all_zero("reset");
    cmd_valid = 2'b00;
    wr_valid = 2'b00;
    resetn = 1'b1;
    ptr_m = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 2'b00 || mem_we !== 1'b0 || done !== 2'b00) begin
      failures++; $display("FAIL post_reset_idle rdy=%b we=%b done=%b exp=0", cmd_ready, mem_we, done);
    end
    step_cycle();
  endtask

  task automatic test_arbitration();
    logic [1:0] gr [$];
    int         gc [$];
    logic [1:0] exp;
    cmd_we = 2'b00;
    cmd_count = {CNTW'(1), CNTW'(1)};
    cmd_addr = {AW'($urandom), AW'($urandom)};
    cmd_step = {AW'(1), AW'(1)};
    cmd_valid = 2'b11;
    for (int cyc = 0; cyc < 80 && gr.size() < 4; cyc++) begin
      @(negedge clk);
      if (cmd_ready != 2'b00) begin
        gr.push_back(cmd_ready);
        gc.push_back(cyc);
      end
      step_cycle();
    end
    cmd_valid = 2'b00;
    repeat (10) step_cycle();
    checks++;
    if (gr.size() != 4) begin
      failures++; $display("FAIL arb_count got=%0d exp=4", gr.size());
    end
    for (int i = 0; i < gr.size(); i++) begin
      exp = 2'b00;
      exp[ptr_m] = 1'b1;
      checks++;
      if (gr[i] !== exp) begin
        failures++; $display("FAIL arb_grant%0d got=%b exp=%b", i, gr[i], exp);
      end
      ptr_m = ~ptr_m;
      if (i > 0) begin
        checks++;
        if (gc[i] - gc[i-1] < 6) begin
          failures++; $display("FAIL arb_gap%0d got=%0d exp>=6", i, gc[i] - gc[i-1]);
        end
      end
    end
  endtask

  task automatic test_read3();
    run_cmd(1'b0, 1'b0, 15'h0010, 15'h0004, 14'h0011, 14'h0022, 3, 1'b0, '0, 1'b0);
  endtask

  task automatic test_write_stall();
    run_cmd(1'b1, 1'b1, 15'h0100, 15'h0020, 14'h0003, 14'h0044, 2, 1'b1, 64'b1010, 1'b0);
  endtask

  task automatic test_zero_count();
    run_cmd(1'b0, 1'b0, 15'h1234, 15'h0001, 14'h0001, 14'h0001, 0, 1'b0, '0, 1'b0);
    run_cmd(1'b1, 1'b1, 15'h2345, 15'h0001, 14'h0002, 14'h0002, 0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_wrap();
    run_cmd(1'b0, 1'b0, 15'h7FFE, 15'h0003, 14'h0005, 14'h0006, 2, 1'b0, '0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 14; i++)
      run_cmd(1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom), 14'($urandom),
              14'($urandom), $urandom_range(0, 7), 1'b0, '0, 1'($urandom));
  endtask

  task automatic test_reset_mid_read();
    logic acc;
    cmd_we = 2'b00;
    cmd_count = {CNTW'(8), CNTW'(8)};
    cmd_addr = {AW'($urandom), AW'($urandom)};
    cmd_step = {AW'(5), AW'(5)};
    cmd_valid = 2'b01;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready == 2'b01) acc = 1'b1;
      step_cycle();
    end
    cmd_valid = 2'b00;
    checks++;
    if (!acc) begin
      failures++; $display("FAIL midreset_accept got=0 exp=1");
    end
    repeat (3) step_cycle();
    #2 resetn = 1'b0;
    #1 check_all_zero("async_reset");
    ptr_m = 1'b0;
    repeat (2) step_cycle();
    resetn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem_dat_r = rand_dw();
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0 || done !== 2'b00 || mem_we !== 1'b0) begin
        failures++; $display("FAIL post_abort i=%0d rdv=%b done=%b we=%b exp=0", i, rd_valid, done, mem_we);
      end
      step_cycle();
    end
    run_cmd(1'b0, 1'b0, 15'h0040, 15'h0008, 14'h0007, 14'h0009, 2, 1'b0, '0, 1'b1);
  endtask

  initial begin
    resetn = 1'b0;
    cmd_valid = '0; cmd_we = '0; cmd_addr = '0; cmd_stride_x = '0; cmd_stride_y = '0;
    cmd_step = '0; cmd_count = '0; wr_data = '0; wr_valid = '0; mem_dat_r = '0;
    ptr_m = 1'b0;
    #1;
    test_reset();
    test_arbitration();
    test_read3();
    test_write_stall();
    test_zero_count();
    test_wrap();
    test_random();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/risk_mem_ctrl.md
# risk_mem_ctrl

Sequencer and two-port arbiter in front of the strided tile memory `risk_mem`. It accepts tile-transfer commands from two requesters (e.g. load unit and store unit) and grants them round-robin. Each command becomes a back-to-back stream of one tile access per cycle, and the block aligns write data and write enable to the memory's internal pipeline. Read tiles are returned with requester ID and last flag.

## Interface
Parameters:
- `SZ`, 4: tile edge; tile = SZ*SZ elements.
- `LOGCNT`, 5: log2 of the BRAM bank count; AW = 10+LOGCNT.
- `BITS`, 18: element width; DW = BITS*SZ*SZ.
- `CNTW`, 8: tile-count width.
- `RD_LAT`, 4: cycles from address issue to valid `mem_dat_r`.

Ports (`[r]` = per-requester slice, r in {0,1}):
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `cmd_valid` in 2; `cmd_ready` out 2: command handshake.
- `cmd_we` in 2: 1 = write command, 0 = read command.
- `cmd_addr` in 2*AW: base address.
- `cmd_stride_x`, `cmd_stride_y` in 2*(AW-1): strides passed through to memory.
- `cmd_step` in 2*AW: address increment between tiles.
- `cmd_count` in 2*CNTW: number of tiles.
- `wr_data` in 2*DW; `wr_valid` in 2; `wr_ready` out 2: write-tile handshake.
- `rd_data` out DW; `rd_valid` out 1; `rd_id` out 1; `rd_last` out 1: read return. No backpressure.
- `done` out 2: one-cycle pulse when the command completes.
- `mem_addr` out AW; `mem_stride_x`, `mem_stride_y` out AW-1; `mem_dat_w` out DW; `mem_we` out 1; `mem_dat_r` in DW: memory side.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- **IDLE:**
  - If any `cmd_valid` is set, grant by round-robin. The pointer starts at requester 0 after reset.
  - On a grant, pulse `cmd_ready[g]` for one cycle and latch the command. The pointer moves to favour the other requester next time.
  - Go to RUN, or go directly to DRAIN if `cmd_count`==0.
- **RUN, read:**
  - Issue one tile every cycle. `mem_addr` = current address; strides come from the latched command.
  - After each issue: address += step, modulo 2^AW (wraps silently); remaining count -= 1.
- **RUN, write:**
  - `wr_ready[g]` is 1 throughout RUN. The non-owner's `wr_ready` is 0.
  - A tile issues only in a cycle where `wr_valid[g]` && `wr_ready[g]`. Otherwise there is no issue and the address holds.
- RUN → DRAIN in the cycle after the last issue.
- **DRAIN:**
  - Read: wait until the last read's `rd_valid` cycle.
  - Write: wait until the cycle after the last `mem_we`.
  - Then pulse `done[g]` and return to IDLE.
- For a zero-count command, DRAIN lasts exactly one cycle with `done` asserted. No memory access and no `rd_valid` occur.
- **Write pipeline alignment** for a tile issued in cycle t:
  - `mem_dat_w` carries its data in t+1.
  - `mem_we`=1 in t+2 only.
  - Non-issue cycles push we=0 into the pipeline.
- **Read return:** a valid-bit shift register of depth RD_LAT tracks read issues.
  - `rd_valid`=1 at t+RD_LAT, with `rd_data`=`mem_dat_r` (combinational), `rd_id`=g.
  - `rd_last`=1 on the final tile.
- **Reset (async, any state):**
  - FSM → IDLE, pointer → 0, all pipelines cleared.
  - All outputs 0: `cmd_ready`, `wr_ready`, `rd_*`, `done`, `mem_addr`, strides, `mem_dat_w`, `mem_we`.
  - An in-flight command is aborted with no `done`.
- Between commands, `mem_addr` and the strides hold their last values. `mem_we` stays 0.

## Timing
- Command accept in cycle c; first possible issue in c+1.
- Read of N tiles with N≥1:
  - Issues in c+1 … c+N.
  - `rd_valid` in c+1+RD_LAT … c+N+RD_LAT.
  - `done` coincides with `rd_last`.
- Write of N tiles with no stalls:
  - `mem_we` high in c+3 … c+N+2.
  - `done` in c+N+3.
- `cmd_ready` is never asserted outside IDLE. The next command can be accepted at the earliest one cycle after `done`.
- Throughput: 1 tile/cycle. Each tile's BRAM access lands exactly 2 cycles after issue, so read/write turnaround needs no bubbles.

## Test plan
- **Read, 3 tiles:** r0, base 0x0010, step 0x0004, count 3. Expect:
  - `mem_addr` 0x0010/0x0014/0x0018 in c+1..c+3.
  - `rd_valid` in c+5..c+7, `rd_id`=0, `rd_last` and `done[0]` in c+7.
- **Write with stall:** r1, count 2; `wr_valid` pattern 1,0,1. Expect:
  - Issues in c+1 and c+3.
  - `mem_we` in c+3 and c+5; `mem_dat_w` matches the tile data in c+2 and c+4.
  - `done[1]` in c+6.
- **Arbitration:** both `cmd_valid` held continuously, count 1 each. Expect grants alternating 0,1,0,1 after reset, with no back-to-back `cmd_ready` to the same requester.
- **Zero count:** r0, count 0. Expect `done[0]` in c+1, no issue, `mem_we`=0, `rd_valid`=0.
- **Wrap-around:** base 0x7FFE, step 3, count 2 (AW=15). Expect `mem_addr` 0x7FFE then 0x0001.
- **Reset mid-read:** reset asserted during RUN of a count-8 read. Expect:
  - All outputs 0 immediately (async).
  - No `rd_valid` or `done` after release.
  - Next command accepted normally with the round-robin pointer at 0.
